// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared I2C definitions used by both the I2C master and the PCF8574-style
// target: the target state encoding and the open-drain SDA level names.
// No ports (package).
package i2c_pkg;

    // Target receive/transmit phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_tgt_state_e;

    // SDA level during the ninth (acknowledge) bit.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Open-drain "not driving" value.
    localparam logic I2C_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Brings one asynchronous bus line into the clk domain through a 2-FF
// synchronizer and keeps one extra history sample for edge detection.
// Ports:
//   clk     in   system clock
//   line_in in   raw bus level (asynchronous)
//   level   out  synchronized level
//   rise    out  one-cycle pulse on a synchronized 0->1 transition
//   fall    out  one-cycle pulse on a synchronized 1->0 transition
// The flops are deliberately not reset: they keep tracking the real bus
// during and after reset, so releasing reset can never fabricate an edge
// (and hence a false START/STOP) out of a forced value.
module i2c_line_sync (
    input  logic clk,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_pcf8574_target.sv
// i2c_pcf8574_target
// I2C target modelling a PCF8574 8-bit quasi-bidirectional I/O expander.
// Written bytes are latched onto port_out; reads return port_in.
// Ports:
//   clk       in   system clock (>= 8x SCL rate)
//   reset     in   synchronous active-high reset
//   scl_in    in   bus SCL level (asynchronous)
//   sda_in    in   bus SDA level (asynchronous)
//   scl_out   out  open-drain SCL drive, always released (no stretching)
//   sda_out   out  open-drain SDA drive (0 = pull low, 1 = release)
//   port_out  out  last byte written to this target
//   port_wr   out  one-cycle strobe when port_out updates
//   port_in   in   byte returned on reads
//   busy      out  high from our address ACK until START or STOP
module i2c_pcf8574_target #(
    parameter logic [6:0] ADDR       = 7'h27,
    parameter logic [7:0] PORT_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic [7:0] port_out,
    output logic       port_wr,
    input  logic [7:0] port_in,
    output logic       busy
);
    import i2c_pkg::*;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_tgt_state_e state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           sda_q, sda_d;
    logic [7:0]     port_q, port_d;
    logic           port_wr_q, port_wr_d;
    logic           busy_q, busy_d;
    logic           ack_phase_q, ack_phase_d;

    logic       scl_stable_high;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;

    // SCL high and not rising means it was high in the previous sample too,
    // so an SCL edge always wins over a simultaneous SDA edge.
    assign scl_stable_high = scl_lvl & ~scl_rise;
    assign start_det       = sda_fall & scl_stable_high;
    assign stop_det        = sda_rise & scl_stable_high;
    assign rx_byte         = {shift_q[6:0], sda_lvl};

    // Next-state logic. START/STOP override whatever phase we are in.
    // ack_phase marks the second half of an ACK slot: in ADDR_ACK and
    // WRITE_ACK it means "ACK is being driven"; in READ_ACK it means
    // "master ACKed, send the next byte at the coming falling edge".
    // For reads, cnt counts bits already placed on SDA.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        sda_d       = sda_q;
        port_d      = port_q;
        port_wr_d   = 1'b0;
        busy_d      = busy_q;
        ack_phase_d = ack_phase_q;

        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            sda_d   = I2C_RELEASE;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            sda_d   = I2C_RELEASE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ack_phase_d = 1'b0;
                            state_d     = (rx_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end

                // shift_q still holds the address byte here, so bit 0 is R/W.
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_d       = I2C_ACK;
                            ack_phase_d = 1'b1;
                            if (state_q == ST_ADDR_ACK) begin
                                busy_d = 1'b1;
                            end
                        end else begin
                            ack_phase_d = 1'b0;
                            cnt_d       = 4'd0;
                            if (state_q == ST_WRITE_ACK || !shift_q[0]) begin
                                sda_d   = I2C_RELEASE;
                                state_d = ST_WRITE;
                            end else begin
                                shift_d = port_in;
                                sda_d   = port_in[7];
                                cnt_d   = 4'd1;
                                state_d = ST_READ;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            port_d      = rx_byte;
                            port_wr_d   = 1'b1;
                            ack_phase_d = 1'b0;
                            state_d     = ST_WRITE_ACK;
                        end
                    end
                end

                ST_READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_d       = I2C_RELEASE;
                            ack_phase_d = 1'b0;
                            state_d     = ST_READ_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            sda_d   = shift_q[6];
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end

                ST_READ_ACK: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (sda_lvl == I2C_ACK) begin
                            ack_phase_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        shift_d     = port_in;
                        sda_d       = port_in[7];
                        cnt_d       = 4'd1;
                        ack_phase_d = 1'b0;
                        state_d     = ST_READ;
                    end
                end

                ST_IGNORE: begin
                end

                default: begin
                    state_d = ST_IDLE;
                    sda_d   = I2C_RELEASE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            cnt_q       <= 4'd0;
            sda_q       <= I2C_RELEASE;
            port_q      <= PORT_RESET;
            port_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            ack_phase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sda_q       <= sda_d;
            port_q      <= port_d;
            port_wr_q   <= port_wr_d;
            busy_q      <= busy_d;
            ack_phase_q <= ack_phase_d;
        end
    end

    assign scl_out  = 1'b1;
    assign sda_out  = sda_q;
    assign port_out = port_q;
    assign port_wr  = port_wr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// tb_i2c_pcf8574_target
// Bit-banged I2C master driving the PCF8574 target over a wired-AND bus.
// Expected port writes go into a queue as they are issued; a monitor pops
// them whenever the target strobes port_wr.
module tb_i2c_pcf8574_target;
    import i2c_pkg::*;

    localparam logic [6:0] DUT_ADDR   = 7'h27;
    localparam logic [7:0] PORT_RST   = 8'hFF;
    localparam int         Q          = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       scl_out;
    logic       sda_out;
    logic [7:0] port_out;
    logic       port_wr;
    logic [7:0] port_in;
    logic       busy;

    wire scl_bus = scl_m & scl_out;
    wire sda_bus = sda_m & sda_out;

    i2c_pcf8574_target #(
        .ADDR       (DUT_ADDR),
        .PORT_RESET (PORT_RST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_bus),
        .sda_in   (sda_bus),
        .scl_out  (scl_out),
        .sda_out  (sda_out),
        .port_out (port_out),
        .port_wr  (port_wr),
        .port_in  (port_in),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_port_q[$];
    logic [7:0] tx_data[$];
    logic [7:0] model_port = PORT_RST;
    int         strobe_count = 0;
    int         sda_low_count = 0;
    int         busy_high_count = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] mon_exp;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every port_wr strobe against the scoreboard queue
    // and enforces the one-cycle strobe width.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (sda_out == 1'b0) sda_low_count++;
            if (busy == 1'b1) busy_high_count++;
            if (prev_wr) checkOutput("port_wr_one_cycle", port_wr, 0);
            if (port_wr) begin
                strobe_count++;
                if (exp_port_q.size() == 0) begin
                    checkOutput("unexpected_port_wr", port_out, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_port_q.pop_front();
                    checkOutput("port_out_on_wr", port_out, mon_exp);
                end
            end
            prev_wr = port_wr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    // One SCL period; returns bus SDA and the target's own drive mid-high.
    task automatic send_bit(input logic b, output logic seen, output logic drv);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        seen = sda_bus;
        drv  = sda_out;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack, output logic drv);
        logic s, dv;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s, dv);
        send_bit(1'b1, ack, drv);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic s, dv;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s, dv);
            d[i] = s;
        end
        send_bit(master_ack, s, dv);
    endtask

    // Full transaction: addressing, then tx_data writes or nbytes reads.
    task automatic applyStimulus(input logic is_read, input logic [6:0] addr, input int nbytes);
        logic       ack, drv, match;
        logic [7:0] rd;
        match = (addr == DUT_ADDR);
        i2c_start();
        send_byte({addr, is_read}, ack, drv);
        checkOutput("addr_ack", ack, match ? I2C_ACK : I2C_NACK);
        checkOutput("addr_ack_drive", drv, match ? I2C_ACK : I2C_RELEASE);
        checkOutput("busy_after_addr", busy, match);
        for (int i = 0; i < nbytes; i++) begin
            if (!is_read) begin
                if (match) begin
                    exp_port_q.push_back(tx_data[i]);
                    model_port = tx_data[i];
                end
                send_byte(tx_data[i], ack, drv);
                checkOutput("data_ack", ack, match ? I2C_ACK : I2C_NACK);
            end else begin
                recv_byte((i == nbytes - 1) ? I2C_NACK : I2C_ACK, rd);
                checkOutput("read_data", rd, match ? port_in : 8'hFF);
            end
        end
        i2c_stop();
        tick(6);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("port_out_model", port_out, model_port);
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       ack, drv, s, dv;
        logic [7:0] rd;
        int         base_strobes, low_before, busy_before;
        logic       seen_drive;

        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; port_in = 8'h00;
        tick(6);
        reset = 1'b0;
        tick(2);
        checkOutput("reset_sda_out", sda_out, 1);
        checkOutput("reset_scl_out", scl_out, 1);
        checkOutput("reset_port_out", port_out, PORT_RST);
        checkOutput("reset_port_wr", port_wr, 0);
        checkOutput("reset_busy", busy, 0);

        $display("[TB] single write 0xA5");
        tx_data = '{8'hA5};
        applyStimulus(1'b0, DUT_ADDR, 1);

        $display("[TB] address mismatch");
        low_before = sda_low_count; busy_before = busy_high_count;
        tx_data = '{8'h12};
        applyStimulus(1'b0, 7'h3F, 1);
        checkOutput("mismatch_sda_low_cycles", sda_low_count - low_before, 0);
        checkOutput("mismatch_busy_cycles", busy_high_count - busy_before, 0);

        $display("[TB] read 0x5A with NACK");
        port_in = 8'h5A;
        applyStimulus(1'b1, DUT_ADDR, 1);
        checkOutput("read_released_after_stop", sda_out, 1);

        $display("[TB] multi-byte write");
        base_strobes = strobe_count;
        tx_data = '{8'h01, 8'h02, 8'h03};
        i2c_start();
        send_byte({DUT_ADDR, 1'b0}, ack, drv);
        checkOutput("mb_addr_ack", ack, I2C_ACK);
        for (int i = 0; i < 3; i++) begin
            exp_port_q.push_back(tx_data[i]);
            model_port = tx_data[i];
            send_byte(tx_data[i], ack, drv);
            checkOutput("mb_data_ack", ack, I2C_ACK);
        end
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(1);
        checkOutput("mb_busy_before_stop_seen", busy, 1);
        tick(4);
        checkOutput("mb_busy_after_stop", busy, 0);
        checkOutput("mb_strobes", strobe_count - base_strobes, 3);
        checkOutput("mb_port_out", port_out, 8'h03);
        tick(Q);

        $display("[TB] repeated START mid-byte");
        base_strobes = strobe_count;
        port_in = 8'hC3;
        i2c_start();
        send_byte({DUT_ADDR, 1'b0}, ack, drv);
        checkOutput("rs_addr_ack", ack, I2C_ACK);
        for (int i = 0; i < 4; i++) send_bit(i[0], s, dv);
        i2c_start();
        send_byte({DUT_ADDR, 1'b1}, ack, drv);
        checkOutput("rs_read_addr_ack", ack, I2C_ACK);
        recv_byte(I2C_NACK, rd);
        checkOutput("rs_read_data", rd, 8'hC3);
        i2c_stop();
        tick(6);
        checkOutput("rs_no_strobe", strobe_count - base_strobes, 0);
        checkOutput("rs_port_unchanged", port_out, model_port);

        $display("[TB] reset during WRITE_ACK");
        i2c_start();
        send_byte({DUT_ADDR, 1'b0}, ack, drv);
        exp_port_q.push_back(8'h6C);
        for (int i = 7; i >= 0; i--) begin
            rd = 8'h6C;
            send_bit(rd[i], s, dv);
        end
        sda_m = 1'b1;
        seen_drive = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sda_out == 1'b0) begin
                seen_drive = 1'b1;
                break;
            end
            tick(1);
        end
        checkOutput("rst_ack_drive_seen", seen_drive, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_port = PORT_RST;
        checkOutput("rst_sda_released", sda_out, 1);
        checkOutput("rst_port_out", port_out, PORT_RST);
        checkOutput("rst_busy", busy, 0);
        tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
        low_before = sda_low_count;
        send_byte({DUT_ADDR, 1'b0}, ack, drv);
        checkOutput("rst_bus_ignored_ack", ack, I2C_NACK);
        checkOutput("rst_bus_ignored_low", sda_low_count - low_before, 0);
        i2c_stop();
        tick(4);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DUT_ADDR;
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            port_in = 8'($urandom);
            tx_data.delete();
            for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom));
            applyStimulus(rw, a, n);
        end

        tick(10);
        checkOutput("scoreboard_drained", exp_port_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
